usb_sie_tx: RTL and testbench
=============================

Name: usb_sie_tx

Overview:
- Transmit half of the USB host serial interface engine. Sits directly downstream of the CPU register block.
- Accepts a transfer request (token fields, length, data toggle), builds the token packet with CRC5, and drives it onto the UTMI+ transmit interface.
- For OUT/SETUP transfers it then sends a DATA0/DATA1 packet from the TX FIFO with CRC16.
- Signals completion so the receive side can arm, and so the register block can raise its done interrupt.

Parameters:
- IPG_CYCLES, 16: idle clocks with txvalid low between the token packet and the data packet.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- start_i  in  1  transfer request level; held until ack_o
- ack_o  out  1  one-cycle pulse: request accepted, inputs latched
- sof_transfer_i  in  1  request is an SOF (token only, no done pulse)
- in_transfer_i  in  1  request is IN (token only)
- token_pid_i  in  8  full PID byte (PID plus complement)
- token_dev_i  in  7  device address, or frame[6:0] for SOF
- token_ep_i  in  4  endpoint, or frame[10:7] for SOF
- data_len_i  in  16  OUT/SETUP payload byte count
- data_idx_i  in  1  0 = DATA0 (0xC3), 1 = DATA1 (0x4B)
- tx_data_i  in  8  TX FIFO head; valid the cycle after tx_pop_o and held until the next pop
- tx_pop_o  out  1  TX FIFO pop strobe
- utmi_data_o  out  8  UTMI transmit byte
- utmi_txvalid_o  out  1  UTMI transmit valid
- utmi_txready_i  in  1  UTMI byte accepted
- tx_done_o  out  1  one-cycle pulse: last packet of a non-SOF request fully accepted
- idle_o  out  1  high in IDLE only

Behaviour:
- Reset: state IDLE. ack_o, tx_pop_o, utmi_txvalid_o and tx_done_o are 0; utmi_data_o = 0x00; idle_o = 1.
- Reset asserted mid-packet: txvalid drops at that clock edge; no done pulse is generated.
- Byte transfer rule: a byte is transferred when txvalid & txready are both high. utmi_data_o is stable while txvalid is high and txready is low. txvalid stays continuously high from a packet's PID byte to its last byte.
- IDLE: if start_i is sampled high, pulse ack_o for that cycle and latch all request inputs. Go to TOK_PID. start_i is ignored in every other state.
- TOK_PID: drive token_pid. On transfer, go to TOK1.
- TOK1: drive {ep[0], dev[6:0]}. On transfer, go to TOK2.
- TOK2: drive {crc5[4:0], ep[3:1]}. crc5 is the complement of the CRC5 over the 11 bits {ep,dev}, LSB first, polynomial x^5+x^2+1, seed 0x1F.
- TOK2 exit on transfer:
  - SOF: go to IDLE with no done pulse.
  - IN: pulse tx_done_o and go to IDLE.
  - Otherwise: go to IPG.
- IPG: txvalid low for exactly IPG_CYCLES clocks, then go to DAT_PID.
- DAT_PID: drive 0xC3 or 0x4B per the latched data_idx. On the first cycle in this state, pulse tx_pop_o only if len ≠ 0 (prefetch). Load remaining = len.
- DAT_PID exit on transfer: if len = 0, go to CRC_LO; otherwise go to DATA.
- DATA: utmi_data_o = tx_data_i (passed straight through). On each transfer:
  - Fold the byte into the CRC16 and decrement remaining.
  - Pulse tx_pop_o in the same cycle if remaining > 1 before the decrement.
  - When remaining reaches 0, go to CRC_LO.
- Prefetch guarantees the next byte is on tx_data_i one cycle after a transfer, even with back-to-back txready.
- CRC16: polynomial 0x8005, seed 0xFFFF, LSB-first, complemented. The low byte is sent in CRC_LO, the high byte in CRC_HI. Zero-length packet CRC = 0x0000.
- CRC_HI on transfer: pulse tx_done_o and go to IDLE.
- Total pops per OUT request equal len exactly. An empty FIFO is not detected; the FIFO head byte is repeated.
- Widths: remaining is 16 bits; len 0..65535 accepted without clamping.
- Latency: ack_o fires in the same cycle start_i is first seen in IDLE. txvalid rises on the next clock.
- Simultaneous start_i and tx_done_o: not possible. A new ack is earliest one cycle after returning to IDLE.

Test Plan:
- SOF: dev = 0x15, ep = 0xE, pid = 0xA5, txready always 1 -> bytes A5, 15, BF. No tx_done_o. idle_o returns high 3 cycles after txvalid rises.
- IN token: pid = 0x69, dev = 0x3A, ep = 0xA -> bytes 69, 3A, E5 (crc5 = 0x1C). Single tx_done_o pulse on the cycle of the last transfer.
- OUT, len = 4, FIFO {00, 01, 02, 03}, data_idx = 0, txready = 1 -> token bytes, then txvalid low exactly 16 clocks, then C3 00 01 02 03 plus CRC bytes matching the bench CRC16 model. Exactly 4 pops; tx_done_o pulses once.
- Zero-length SETUP with data_idx = 1 -> after the IPG: 4B 00 00. No pops.
- txready toggling (1 clock in 3), OUT len = 3 -> utmi_data_o is stable while not ready. txvalid never drops inside a packet. Byte order and pop count are correct.
- rst_i asserted during DATA, then a new SOF request -> txvalid is 0 the next clock with no done pulse. The new request is acked and transmitted correctly.

Source files
------------

// File: rtl/usb_sie_tx.sv
// usb_sie_tx - transmit half of the USB host serial interface engine.
//
// Takes one transfer request from the register block, sends the token
// packet (PID, addr/ep, CRC5) over the UTMI+ transmit interface and, for
// OUT/SETUP requests, follows it after an inter-packet gap with a DATA0/1
// packet read from the TX FIFO and closed with CRC16.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   start_i / ack_o           request level / one-cycle accept pulse
//   sof_transfer_i            request is SOF (token only, no done pulse)
//   in_transfer_i             request is IN (token only)
//   token_pid_i/dev_i/ep_i    token fields (frame number for SOF)
//   data_len_i, data_idx_i    payload length, DATA0/DATA1 select
//   tx_data_i / tx_pop_o      TX FIFO head byte / pop strobe
//   utmi_data_o/txvalid_o     UTMI+ transmit byte and valid
//   utmi_txready_i            UTMI+ byte accepted
//   tx_done_o                 last packet of a non-SOF request accepted
//   idle_o                    engine idle
module usb_sie_tx #(
    parameter int IPG_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        ack_o,
    input  logic        sof_transfer_i,
    input  logic        in_transfer_i,
    input  logic [7:0]  token_pid_i,
    input  logic [6:0]  token_dev_i,
    input  logic [3:0]  token_ep_i,
    input  logic [15:0] data_len_i,
    input  logic        data_idx_i,
    input  logic [7:0]  tx_data_i,
    output logic        tx_pop_o,
    output logic [7:0]  utmi_data_o,
    output logic        utmi_txvalid_o,
    input  logic        utmi_txready_i,
    output logic        tx_done_o,
    output logic        idle_o
);

    localparam int CW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_TOK_PID, S_TOK1, S_TOK2, S_IPG,
        S_DAT_PID, S_DATA, S_CRC_LO, S_CRC_HI
    } state_t;

    state_t         state_q, state_d;
    logic           sof_q, sof_d;
    logic           in_q, in_d;
    logic [7:0]     pid_q, pid_d;
    logic [6:0]     dev_q, dev_d;
    logic [3:0]     ep_q, ep_d;
    logic [15:0]    len_q, len_d;
    logic           idx_q, idx_d;
    logic [15:0]    rem_q, rem_d;
    logic [15:0]    crc_q, crc_d;
    logic [CW-1:0]  ipg_q, ipg_d;
    logic           first_q, first_d;   // first cycle of DAT_PID: prefetch pop
    logic [4:0]     crc5;

    // Token CRC5 over {ep,dev}, fed LSB first. The complemented register is
    // placed as-is in the top five bits of the last token byte.
    function automatic logic [4:0] calc_crc5(input logic [10:0] bits);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (c[4] ^ bits[i]) c = {c[3:0], 1'b0} ^ 5'h05;
            else                c = {c[3:0], 1'b0};
        end
        return ~c;
    endfunction

    // Data CRC16 in reflected form (0x8005 reversed = 0xA001), so the
    // complemented low byte is the first one on the wire.
    function automatic logic [15:0] crc16_upd(input logic [15:0] c,
                                              input logic [7:0]  d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always_comb crc5 = calc_crc5({ep_q, dev_q});

    always_comb begin
        state_d        = state_q;
        sof_d          = sof_q;
        in_d           = in_q;
        pid_d          = pid_q;
        dev_d          = dev_q;
        ep_d           = ep_q;
        len_d          = len_q;
        idx_d          = idx_q;
        rem_d          = rem_q;
        crc_d          = crc_q;
        ipg_d          = ipg_q;
        first_d        = 1'b0;
        ack_o          = 1'b0;
        tx_pop_o       = 1'b0;
        utmi_data_o    = 8'h00;
        utmi_txvalid_o = 1'b0;
        tx_done_o      = 1'b0;
        idle_o         = 1'b0;

        case (state_q)
            S_IDLE: begin
                idle_o = 1'b1;
                if (start_i) begin
                    ack_o   = 1'b1;
                    sof_d   = sof_transfer_i;
                    in_d    = in_transfer_i;
                    pid_d   = token_pid_i;
                    dev_d   = token_dev_i;
                    ep_d    = token_ep_i;
                    len_d   = data_len_i;
                    idx_d   = data_idx_i;
                    state_d = S_TOK_PID;
                end
            end
            S_TOK_PID: begin
                utmi_txvalid_o = 1'b1;
                utmi_data_o    = pid_q;
                if (utmi_txready_i) state_d = S_TOK1;
            end
            S_TOK1: begin
                utmi_txvalid_o = 1'b1;
                utmi_data_o    = {ep_q[0], dev_q};
                if (utmi_txready_i) state_d = S_TOK2;
            end
            S_TOK2: begin
                utmi_txvalid_o = 1'b1;
                utmi_data_o    = {crc5, ep_q[3:1]};
                if (utmi_txready_i) begin
                    if (sof_q) begin
                        state_d = S_IDLE;
                    end else if (in_q) begin
                        tx_done_o = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        ipg_d   = '0;
                        state_d = S_IPG;
                    end
                end
            end
            S_IPG: begin
                if (ipg_q == CW'(IPG_CYCLES - 1)) begin
                    first_d = 1'b1;
                    state_d = S_DAT_PID;
                end else begin
                    ipg_d = ipg_q + 1'b1;
                end
            end
            S_DAT_PID: begin
                utmi_txvalid_o = 1'b1;
                utmi_data_o    = idx_q ? 8'h4B : 8'hC3;
                // Prefetch so the first payload byte is already on tx_data_i
                // by the time DATA is entered.
                tx_pop_o = first_q && (len_q != 16'd0);
                rem_d    = len_q;
                crc_d    = 16'hFFFF;
                if (utmi_txready_i)
                    state_d = (len_q == 16'd0) ? S_CRC_LO : S_DATA;
            end
            S_DATA: begin
                utmi_txvalid_o = 1'b1;
                utmi_data_o    = tx_data_i;
                if (utmi_txready_i) begin
                    crc_d    = crc16_upd(crc_q, tx_data_i);
                    rem_d    = rem_q - 16'd1;
                    // Pop for the byte after this one; the last byte needs none.
                    tx_pop_o = (rem_q > 16'd1);
                    if (rem_q == 16'd1) state_d = S_CRC_LO;
                end
            end
            S_CRC_LO: begin
                utmi_txvalid_o = 1'b1;
                utmi_data_o    = ~crc_q[7:0];
                if (utmi_txready_i) state_d = S_CRC_HI;
            end
            S_CRC_HI: begin
                utmi_txvalid_o = 1'b1;
                utmi_data_o    = ~crc_q[15:8];
                if (utmi_txready_i) begin
                    tx_done_o = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            sof_q   <= 1'b0;
            in_q    <= 1'b0;
            pid_q   <= 8'h00;
            dev_q   <= 7'h00;
            ep_q    <= 4'h0;
            len_q   <= 16'h0000;
            idx_q   <= 1'b0;
            rem_q   <= 16'h0000;
            crc_q   <= 16'hFFFF;
            ipg_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sof_q   <= sof_d;
            in_q    <= in_d;
            pid_q   <= pid_d;
            dev_q   <= dev_d;
            ep_q    <= ep_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            crc_q   <= crc_d;
            ipg_q   <= ipg_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_usb_sie_tx.sv
// Bench for usb_sie_tx: directed requests from the test plan followed by
// randomized requests, checked against a packet-level reference model.
module tb_usb_sie_tx;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        ack_o;
    logic        sof_transfer_i = 1'b0;
    logic        in_transfer_i = 1'b0;
    logic [7:0]  token_pid_i = 8'h00;
    logic [6:0]  token_dev_i = 7'h00;
    logic [3:0]  token_ep_i = 4'h0;
    logic [15:0] data_len_i = 16'h0;
    logic        data_idx_i = 1'b0;
    logic [7:0]  tx_data_i = 8'h00;
    logic        tx_pop_o;
    logic [7:0]  utmi_data_o;
    logic        utmi_txvalid_o;
    logic        utmi_txready_i = 1'b1;
    logic        tx_done_o;
    logic        idle_o;

    int tests = 0;
    int fails = 0;

    usb_sie_tx #(.IPG_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ack_o(ack_o),
        .sof_transfer_i(sof_transfer_i), .in_transfer_i(in_transfer_i),
        .token_pid_i(token_pid_i), .token_dev_i(token_dev_i),
        .token_ep_i(token_ep_i), .data_len_i(data_len_i),
        .data_idx_i(data_idx_i), .tx_data_i(tx_data_i), .tx_pop_o(tx_pop_o),
        .utmi_data_o(utmi_data_o), .utmi_txvalid_o(utmi_txvalid_o),
        .utmi_txready_i(utmi_txready_i), .tx_done_o(tx_done_o),
        .idle_o(idle_o)
    );

    always #5 clk = ~clk;

    // ---------------- environment: txready pattern ----------------
    int ready_mode = 0;   // 0 always ready, 1 one clock in three, 2 random
    int rcyc = 0;
    always @(posedge clk) begin
        rcyc <= rcyc + 1;
        case (ready_mode)
            0:       utmi_txready_i <= 1'b1;
            1:       utmi_txready_i <= (rcyc % 3 == 0);
            default: utmi_txready_i <= 1'($urandom % 2);
        endcase
    end

    // ---------------- environment: TX FIFO ----------------
    logic [7:0] fifo[$];
    int pop_idx = 0;
    always @(posedge clk) begin
        if (ack_o) begin
            pop_idx <= 0;
        end else if (tx_pop_o && !rst_i) begin
            if (pop_idx < fifo.size()) tx_data_i <= fifo[pop_idx];
            pop_idx <= pop_idx + 1;
        end
    end

    // ---------------- monitor (samples on falling edge) ----------------
    logic [7:0] got[$];
    int   pops = 0, dones = 0, done_bad = 0, pkts = 0, stab_err = 0;
    int   gap = 0, last_gap = 0;
    logic prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;
    always @(negedge clk) begin
        if (ack_o) begin
            got.delete();
            pops = 0; dones = 0; done_bad = 0; pkts = 0; stab_err = 0;
            gap = 0; last_gap = 0;
        end
        if (!rst_i) begin
            if (utmi_txvalid_o && utmi_txready_i) got.push_back(utmi_data_o);
            if (tx_pop_o) pops++;
            if (tx_done_o) begin
                dones++;
                if (!(utmi_txvalid_o && utmi_txready_i)) done_bad++;
            end
            if (utmi_txvalid_o && !prev_v) begin
                pkts++;
                if (gap > 0) last_gap = gap;
                gap = 0;
            end
            if (!utmi_txvalid_o && !idle_o) gap++;
            if (utmi_txvalid_o && prev_v && !prev_r && utmi_data_o !== prev_d)
                stab_err++;
        end
        prev_v = utmi_txvalid_o;
        prev_r = utmi_txready_i;
        prev_d = utmi_data_o;
    end

    // ---------------- reference model ----------------
    // CRC5: polynomial division of the 11 token bits (LSB first), x^5+x^2+1.
    function automatic logic [4:0] m_crc5(input logic [6:0] dev,
                                          input logic [3:0] ep);
        int c;
        logic [10:0] b;
        b = {ep, dev};
        c = 31;
        for (int i = 0; i < 11; i++) begin
            int fb;
            fb = ((c >> 4) & 1) ^ int'(b[i]);
            c = (c << 1) & 31;
            if (fb != 0) c = c ^ 5;
        end
        return 5'((~c) & 31);
    endfunction

    // CRC16 computed in the non-reflected MSB-register form with 0x8005;
    // the wire value is the bit-reversed complement.
    function automatic logic [15:0] m_crc16(input logic [7:0] q[$]);
        logic [15:0] c, r;
        c = 16'hFFFF;
        foreach (q[k]) begin
            for (int i = 0; i < 8; i++) begin
                logic fb;
                fb = c[15] ^ q[k][i];
                c = c << 1;
                if (fb) c = c ^ 16'h8005;
            end
        end
        for (int i = 0; i < 16; i++) r[i] = c[15 - i];
        return ~r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int idle_lat = 0;   // negedges from first token cycle to idle_o high

    // kind: 0 SOF, 1 IN, 2 OUT/SETUP
    task automatic do_req(input int kind, input logic [7:0] pid,
                          input logic [6:0] dev, input logic [3:0] ep,
                          input int len, input logic idx, input int rmode,
                          input bit seq);
        logic [7:0] exp[$];
        logic [15:0] c16;
        int n;
        fifo.delete();
        for (int i = 0; i < len; i++)
            fifo.push_back(seq ? 8'(i) : 8'($urandom));
        exp.delete();
        exp.push_back(pid);
        exp.push_back({ep[0], dev});
        exp.push_back({m_crc5(dev, ep), ep[3:1]});
        if (kind == 2) begin
            exp.push_back(idx ? 8'h4B : 8'hC3);
            foreach (fifo[i]) exp.push_back(fifo[i]);
            c16 = m_crc16(fifo);
            exp.push_back(c16[7:0]);
            exp.push_back(c16[15:8]);
        end
        ready_mode = rmode;

        @(posedge clk); #1;
        sof_transfer_i = (kind == 0);
        in_transfer_i  = (kind == 1);
        token_pid_i = pid; token_dev_i = dev; token_ep_i = ep;
        data_len_i = 16'(len); data_idx_i = idx;
        start_i = 1'b1;
        @(negedge clk);
        check("ack_pulse", 32'(ack_o), 32'd1);
        @(posedge clk); #1;
        start_i = 1'b0;
        check("ack_single", 32'(ack_o), 32'd0);
        check("txvalid_rise", 32'(utmi_txvalid_o), 32'd1);

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!idle_o && n < 500);
        idle_lat = n;
        check("idle_timeout", 32'(idle_o), 32'd1);
        @(negedge clk);

        check("byte_count", 32'(got.size()), 32'(exp.size()));
        foreach (exp[i])
            check($sformatf("byte%0d", i),
                  (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
        check("pops", 32'(pops), (kind == 2) ? 32'(len) : 32'd0);
        check("dones", 32'(dones), (kind == 0) ? 32'd0 : 32'd1);
        check("done_on_xfer", 32'(done_bad), 32'd0);
        check("packets", 32'(pkts), (kind == 2) ? 32'd2 : 32'd1);
        check("stable", 32'(stab_err), 32'd0);
        if (kind == 2) check("ipg_len", 32'(last_gap), 32'd16);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_pop", 32'(tx_pop_o), 32'd0);
        check("rst_txvalid", 32'(utmi_txvalid_o), 32'd0);
        check("rst_done", 32'(tx_done_o), 32'd0);
        check("rst_data", 32'(utmi_data_o), 32'd0);
        check("rst_idle", 32'(idle_o), 32'd1);
        @(posedge clk); #1 rst_i = 1'b0;

        // SOF
        do_req(0, 8'hA5, 7'h15, 4'hE, 0, 1'b0, 0, 1'b0);
        check("sof_crc_byte", (got.size() > 2) ? 32'(got[2]) : 32'hFFFF, 32'hBF);
        check("sof_idle_lat", 32'(idle_lat - 1), 32'd3);
        // IN
        do_req(1, 8'h69, 7'h3A, 4'hA, 0, 1'b0, 0, 1'b0);
        check("in_crc_byte", (got.size() > 2) ? 32'(got[2]) : 32'hFFFF, 32'hE5);
        // OUT len 4, FIFO 00..03, DATA0
        do_req(2, 8'hE1, 7'h05, 4'h1, 4, 1'b0, 0, 1'b1);
        // Zero-length SETUP, DATA1
        do_req(2, 8'h2D, 7'h05, 4'h0, 0, 1'b1, 0, 1'b0);
        check("zlp_pid", (got.size() > 3) ? 32'(got[3]) : 32'hFFFF, 32'h4B);
        check("zlp_crc_lo", (got.size() > 4) ? 32'(got[4]) : 32'hFFFF, 32'h00);
        check("zlp_crc_hi", (got.size() > 5) ? 32'(got[5]) : 32'hFFFF, 32'h00);
        // OUT len 3 with txready one clock in three
        do_req(2, 8'hE1, 7'h22, 4'h3, 3, 1'b1, 1, 1'b0);

        // Reset during DATA
        ready_mode = 0;
        fifo.delete();
        for (int i = 0; i < 6; i++) fifo.push_back(8'(8'h30 + i));
        @(posedge clk); #1;
        sof_transfer_i = 1'b0; in_transfer_i = 1'b0;
        token_pid_i = 8'hE1; token_dev_i = 7'h11; token_ep_i = 4'h2;
        data_len_i = 16'd6; data_idx_i = 1'b0; start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        n = 0;
        while (got.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_data", 32'(got.size() >= 5), 32'd1);
        check("in_packet", 32'(utmi_txvalid_o), 32'd1);
        @(posedge clk); #1 rst_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0;
        check("rst_mid_txvalid", 32'(utmi_txvalid_o), 32'd0);
        check("rst_mid_idle", 32'(idle_o), 32'd1);
        repeat (3) @(negedge clk);
        check("rst_mid_stay_low", 32'(utmi_txvalid_o), 32'd0);
        check("rst_mid_no_done", 32'(dones), 32'd0);
        do_req(0, 8'hA5, 7'h7F, 4'h5, 0, 1'b0, 0, 1'b0);

        // Randomized requests
        for (int r = 0; r < 10; r++) begin
            int k;
            k = $urandom_range(0, 2);
            do_req(k, 8'($urandom), 7'($urandom), 4'($urandom),
                   $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 2), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
